// File: rtl/rk_ext_fifo_pkg.sv
// Shared definitions for the round-key broadcaster.
// Key modes and the write-time key expansion function.
package rk_pkg;

  localparam logic [2:0] MODE_B8   = 3'b000;
  localparam logic [2:0] MODE_H16  = 3'b001;
  localparam logic [2:0] MODE_W32  = 3'b010;
  localparam logic [2:0] MODE_H16B = 3'b011;
  localparam logic [2:0] MODE_T24  = 3'b100;
  localparam logic [2:0] MODE_D64  = 3'b101;

  localparam int RK_MAX_W = 512;

  typedef enum logic {
    ST_IDLE,
    ST_HALF
  } rk_st_t;

  // Callers truncate the result to their datapath width.
  function automatic logic [RK_MAX_W-1:0] rk_expand(
    input logic [2:0]  mode,
    input logic [63:0] key64,
    input int          data_w = RK_MAX_W
  );
    logic [RK_MAX_W-1:0] r;
    int                  t24;
    r   = '0;
    t24 = (data_w / 24) * 24;
    for (int i = 0; i < RK_MAX_W; i++) begin
      if (i < data_w) begin
        unique case (1'b1)
          (mode == MODE_B8):
            r[i] = key64[6'(i % 8)];
          (mode == MODE_H16),
          (mode == MODE_H16B):
            r[i] = key64[6'(i % 16)];
          (mode == MODE_W32):
            r[i] = key64[6'(i % 32)];
          (mode == MODE_T24):
            r[i] = (i < t24) ? key64[6'(i % 24)] : 1'b0;
          (mode == MODE_D64):
            r[i] = key64[6'(i % 64)];
          default:
            r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rk_ext_fifo_if.sv
// Key-in / expanded-key-out stream bundle.
// rk_tag exists only when RK_ROUND_TAG_EN is defined.
interface rk_ext_fifo_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
`ifdef RK_ROUND_TAG_EN
  , parameter int CNT_W = 5
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [2:0]        alg_mode;
  logic [31:0]       rk_in;
  logic              rk_in_valid;
  logic              rk_in_ready;
  logic [DATA_W-1:0] rk_ext;
  logic              rk_ext_valid;
  logic              rk_ext_ready;
  logic [LW-1:0]     rk_level;
`ifdef RK_ROUND_TAG_EN
  logic [CNT_W-1:0]  rk_tag;
`endif

  modport master (
    output alg_mode, rk_in, rk_in_valid, rk_ext_ready,
`ifdef RK_ROUND_TAG_EN
    input  rk_tag,
`endif
    input  rk_in_ready, rk_ext, rk_ext_valid, rk_level
  );

  modport slave (
    input  alg_mode, rk_in, rk_in_valid, rk_ext_ready,
`ifdef RK_ROUND_TAG_EN
    output rk_tag,
`endif
    output rk_in_ready, rk_ext, rk_ext_valid, rk_level
  );

endinterface

// File: rtl/rk_ext_fifo_core.sv
// Generic synchronous FIFO with level and flush.
// Head reads 0 after clear and holds the last popped entry while empty.
module rk_fifo_core #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          clr;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      clr    <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      clr    <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        clr    <= 1'b0;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // While empty, the slot behind rd_ptr is the last popped entry.
  always_comb begin
    rdata = '0;
    if (clr)        rdata = '0;
    else if (empty) rdata = mem[AW'(rd_ptr - 1'b1)];
    else            rdata = mem[rd_ptr];
  end

endmodule

// File: rtl/rk_ext_fifo.sv
// Buffered round-key broadcaster: two-beat assembler, expansion, FIFO.
// Define RK_ROUND_TAG_EN to add the per-entry round tag output.
module rk_ext_fifo
  import rk_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  rk_ext_fifo_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef RK_ROUND_TAG_EN
  localparam int EW = DATA_W + CNT_W;
`else
  localparam int EW = DATA_W;
`endif

  if ((DATA_W % 64) != 0 || DATA_W < 128 || DATA_W > RK_MAX_W ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1)
  begin : g_bad_param
    $error("rk_ext_fifo: illegal parameter set");
  end

  rk_st_t        state;
  logic [31:0]   beat0;
  logic          accept;
  logic          push;
  logic [2:0]    mode_sel;
  logic [63:0]   key64;
  logic [DATA_W-1:0] ext_w;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  assign accept = bus.rk_in_valid && bus.rk_in_ready;

  // The second beat of a 64-bit key ignores alg_mode.
  assign mode_sel = (state == ST_HALF) ? MODE_D64 : bus.alg_mode;
  assign key64    = (state == ST_HALF) ? {bus.rk_in, beat0}
                                       : {32'h0, bus.rk_in};
  assign push     = accept && !flush &&
                    (state == ST_HALF || bus.alg_mode != MODE_D64);
  assign ext_w    = DATA_W'(rk_expand(mode_sel, key64, DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      beat0 <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (accept) begin
      unique case (1'b1)
        (state == ST_HALF): state <= ST_IDLE;
        (bus.alg_mode == MODE_D64): begin
          state <= ST_HALF;
          beat0 <= bus.rk_in;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RK_ROUND_TAG_EN
  logic [CNT_W-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tag <= '0;
    else if (flush) tag <= '0;
    else if (push)  tag <= tag + 1'b1;
  end

  assign wdata      = {tag, ext_w};
  assign bus.rk_tag = rdata[EW-1 -: CNT_W];
`else
  assign wdata = ext_w;
`endif

  rk_fifo_core #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (bus.rk_ext_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.rk_in_ready  = !full;
  assign bus.rk_ext       = rdata[DATA_W-1:0];
  assign bus.rk_ext_valid = !empty;
  assign bus.rk_level     = level;

endmodule
